// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared types and constants for the multicycle datapath control units.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Supported opcodes, ins[6:0].
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // PC source select codes.
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_ENTRY  = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_opdecode.sv
// Purpose: opcode legality and class decode for the multicycle controller.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow op directly.
// Ports: op (7-bit opcode) in; legal, is_mem, is_load, is_branch, is_jal out.
module mc_opdecode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic       legal,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_branch,
    output logic       is_jal
);

    always_comb begin
        legal     = 1'b0;
        is_mem    = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        case (op)
            OP_R, OP_I: legal = 1'b1;
            OP_LW: begin
                legal   = 1'b1;
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OP_SW: begin
                legal  = 1'b1;
                is_mem = 1'b1;
            end
            OP_BEQ: begin
                legal     = 1'b1;
                is_branch = 1'b1;
            end
            OP_JAL: begin
                legal  = 1'b1;
                is_jal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle CPU control FSM with retired-instruction counter and sticky illegal-opcode flag.
// Latency: FETCH..retire is 3 (BEQ), 4 (R/I/JAL/SW) or 5 (LW) cycles, plus one per mem_ready=0 cycle.
// Backpressure: mem_ready stalls FETCH and MEM; requests stay asserted until mem_ready is seen.
// Ports: clk, rst_n, start, int_req, halt_req, opcode[6:0], zero, mem_ready in;
//        imem_rd, ir_we, dmem_rd, dmem_wr, rf_we, pc_we, pc_sel[1:0], busy, err, retired[31:0] out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [1:0] ENTRY_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        int_req,
    input  logic        halt_req,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        imem_rd,
    output logic        ir_we,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        busy,
    output logic        err,
    output logic [31:0] retired
);

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  op_q;
    logic [6:0]  dec_op;
    logic        retire;
    logic        err_set;
    logic        legal;
    logic        is_mem;
    logic        is_load;
    logic        is_branch;
    logic        is_jal;

    // Legality is judged on the live opcode in DECODE; later states use the latched copy.
    assign dec_op = (state == ST_DECODE) ? opcode : op_q;

    mc_opdecode u_opdecode (
        .op        (dec_op),
        .legal     (legal),
        .is_mem    (is_mem),
        .is_load   (is_load),
        .is_branch (is_branch),
        .is_jal    (is_jal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= 7'd0;
            retired <= 32'd0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                retired <= retired + 32'd1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_rd   = 1'b0;
        ir_we     = 1'b0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        retire    = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // Interrupt wins: load the entry point and retry the fetch next cycle.
                if (int_req) begin
                    pc_we  = 1'b1;
                    pc_sel = ENTRY_SEL;
                end else begin
                    imem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        state_nxt = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_nxt = ST_EXEC;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = zero ? PC_BRANCH : PC_PLUS4;
                    retire = 1'b1;
                end else if (is_mem) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_rd = is_load;
                dmem_wr = !is_load;
                if (mem_ready) begin
                    if (is_load) begin
                        state_nxt = ST_WB;
                    end else begin
                        // Stores retire straight out of MEM.
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                pc_sel = is_jal ? PC_JUMP : PC_PLUS4;
                retire = 1'b1;
            end
            ST_HALT: begin
                if (start) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Every retirement decides between halting and fetching the next instruction.
        if (retire) begin
            state_nxt = halt_req ? ST_HALT : ST_FETCH;
        end
    end

    assign busy = (state != ST_IDLE) && (state != ST_HALT);

endmodule
